// File: rtl/std_mux_pkg.sv
// -----------------------------------------------------------------------------
// std_mux_pkg
// Shared types and constants for the two-input bus mux arbiter (std_mux_arb).
//   state_e  : arbiter FSM states (IDLE, BUSY_1, BUSY_2)
//   SRC_1/2  : select / source encodings (1 = requester 1, 0 = requester 2)
//   CNT_W    : burst counter width (holds up to MAX_BURST-1 = 14)
//   STATS_W  : width of the optional per-requester beat counters
//   sat_inc  : saturating increment for the beat counters
// -----------------------------------------------------------------------------
package std_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_1 = 2'd1,
        BUSY_2 = 2'd2
    } state_e;

    localparam logic SRC_1 = 1'b1;
    localparam logic SRC_2 = 1'b0;

    localparam int CNT_W   = 4;
    localparam int STATS_W = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/std_mux_arb_if.sv
// -----------------------------------------------------------------------------
// std_mux_arb_if
// Bundles the two valid/ready requester channels, the mux select and the
// merged output channel of std_mux_arb.
//   master : requester/consumer side (drives valids, data, out_ready)
//   slave  : arbiter side (drives readys, sel, out_valid, out_data, out_src)
// -----------------------------------------------------------------------------
interface std_mux_arb_if #(
    parameter int WIDTH = 4
);
    logic             valid_1;
    logic [WIDTH-1:0] data_1;
    logic             ready_1;
    logic             valid_2;
    logic [WIDTH-1:0] data_2;
    logic             ready_2;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport master (
        output valid_1, data_1, valid_2, data_2, out_ready,
        input  ready_1, ready_2, sel, out_valid, out_data, out_src
    );

    modport slave (
        input  valid_1, data_1, valid_2, data_2, out_ready,
        output ready_1, ready_2, sel, out_valid, out_data, out_src
    );
endinterface

// File: rtl/std_mux_arb_rr.sv
// -----------------------------------------------------------------------------
// std_mux_arb_rr
// Round-robin pick between the two requesters.
//   valid_1_i, valid_2_i : requester valids
//   lsp_i                : last-served pointer (1 = requester 1 served last)
//   gnt_vld_o            : at least one requester is asking
//   gnt_1_o              : 1 = requester 1 wins, 0 = requester 2 wins
// -----------------------------------------------------------------------------
module std_mux_arb_rr
    import std_mux_pkg::*;
(
    input  logic valid_1_i,
    input  logic valid_2_i,
    input  logic lsp_i,
    output logic gnt_vld_o,
    output logic gnt_1_o
);

    always_comb begin
        gnt_vld_o = valid_1_i | valid_2_i;
        // On a tie the requester that was not served last wins.
        gnt_1_o   = valid_1_i & (~valid_2_i | (lsp_i != SRC_1));
    end

endmodule

// File: rtl/std_mux_arb.sv
// -----------------------------------------------------------------------------
// std_mux_arb
// Round-robin arbiter/sequencer sharing one registered output channel between
// two valid/ready requesters; each grant lasts up to MAX_BURST beats.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : std_mux_arb_if.slave (requester channels, sel, output channel)
//   beats_1/2 : saturating accepted-beat counts (only with STD_MUX_ARB_STATS_EN)
// Parameters: WIDTH (data width), MAX_BURST (beats per grant, 1..15).
// Optional feature macro: STD_MUX_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module std_mux_arb
    import std_mux_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
)
(
    input  logic                clk,
    input  logic                rst,
    std_mux_arb_if.slave        bus
`ifdef STD_MUX_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]  beats_1,
    output logic [STATS_W-1:0]  beats_2
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    state_e           state_q;
    logic             lsp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sel_q;
    logic             out_valid_q, out_valid_d;
    logic             out_src_q, out_src_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic rdy, rdy_1, rdy_2;
    logic acc_1, acc_2, acc;
    logic cur_valid, oth_valid, last_beat, rel;
    logic gnt_vld, gnt_1;

    std_mux_arb_rr u_rr (
        .valid_1_i (bus.valid_1),
        .valid_2_i (bus.valid_2),
        .lsp_i     (lsp_q),
        .gnt_vld_o (gnt_vld),
        .gnt_1_o   (gnt_1)
    );

    // ready depends only on state and the output slot, never on valid.
    always_comb begin
        rdy       = ~out_valid_q | bus.out_ready;
        rdy_1     = (state_q == BUSY_1) & rdy;
        rdy_2     = (state_q == BUSY_2) & rdy;
        acc_1     = rdy_1 & bus.valid_1;
        acc_2     = rdy_2 & bus.valid_2;
        acc       = acc_1 | acc_2;
        cur_valid = (state_q == BUSY_1) ? bus.valid_1 : bus.valid_2;
        oth_valid = (state_q == BUSY_1) ? bus.valid_2 : bus.valid_1;
        last_beat = acc & (cnt_q == LAST_CNT);
        rel       = (state_q != IDLE) & (last_beat | ~cur_valid);
    end

    // Output slot: a new accept overwrites (also when draining in the same
    // cycle); otherwise a drain empties it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (acc) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_1 ? bus.data_1 : bus.data_2;
            out_src_d   = acc_1 ? SRC_1 : SRC_2;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lsp_q       <= SRC_2;
            cnt_q       <= '0;
            sel_q       <= SRC_2;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_2;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        state_q <= gnt_1 ? BUSY_1 : BUSY_2;
                        sel_q   <= gnt_1 ? SRC_1 : SRC_2;
                    end
                end
                BUSY_1, BUSY_2: begin
                    if (rel) begin
                        lsp_q <= (state_q == BUSY_1) ? SRC_1 : SRC_2;
                        cnt_q <= '0;
                        // Hand straight over to a waiting requester: no bubble.
                        if (oth_valid) begin
                            state_q <= (state_q == BUSY_1) ? BUSY_2 : BUSY_1;
                            sel_q   <= (state_q == BUSY_1) ? SRC_2 : SRC_1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (acc) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_1   = rdy_1;
    assign bus.ready_2   = rdy_2;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

`ifdef STD_MUX_ARB_STATS_EN
    logic [STATS_W-1:0] beats_1_q, beats_2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_1_q <= '0;
            beats_2_q <= '0;
        end else begin
            if (acc_1) beats_1_q <= sat_inc(beats_1_q);
            if (acc_2) beats_2_q <= sat_inc(beats_2_q);
        end
    end

    assign beats_1 = beats_1_q;
    assign beats_2 = beats_2_q;
`else
`endif

endmodule

// File: tb/tb_std_mux_arb.sv
// -----------------------------------------------------------------------------
// tb_std_mux_arb
// Directed bench for std_mux_arb: single requester bursts, round-robin ties,
// early release, backpressure and asynchronous reset mid-burst. Accepted beats
// are queued and checked against the output channel in order.
// -----------------------------------------------------------------------------
module tb_std_mux_arb;
    import std_mux_pkg::*;

    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    std_mux_arb_if #(.WIDTH(WIDTH)) bus ();

`ifdef STD_MUX_ARB_STATS_EN
    logic [15:0] beats_1, beats_2;
`endif

    std_mux_arb #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef STD_MUX_ARB_STATS_EN
        ,
        .beats_1 (beats_1),
        .beats_2 (beats_2)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    int               rem1, rem2;
    logic [WIDTH-1:0] d1, d2;
    logic [WIDTH:0]   sbq[$];

    // Values sampled at the falling edge of the most recent cycle.
    logic             s_r1, s_r2, s_a1, s_a2, s_ov, s_sel, s_lsp;
    logic [WIDTH-1:0] s_od;
    logic [CNT_W-1:0] s_cnt;
    state_e           s_st;

    logic [8:0] pat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.valid_1 = (rem1 > 0);
        bus.data_1  = d1;
        bus.valid_2 = (rem2 > 0);
        bus.data_2  = d2;
    endtask

    task automatic cycle();
        logic [WIDTH:0] e;
        @(negedge clk);
        s_r1  = bus.ready_1;
        s_r2  = bus.ready_2;
        s_a1  = bus.valid_1 & bus.ready_1;
        s_a2  = bus.valid_2 & bus.ready_2;
        s_ov  = bus.out_valid;
        s_od  = bus.out_data;
        s_sel = bus.sel;
        s_st  = dut.state_q;
        s_lsp = dut.lsp_q;
        s_cnt = dut.cnt_q;
        if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            assert (sbq.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_unexpected: observed beat %0h expected none", {bus.out_src, bus.out_data});
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_beat", 32'({bus.out_src, bus.out_data}), 32'(e));
            end
        end
        if (s_a1) sbq.push_back({SRC_1, d1});
        if (s_a2) sbq.push_back({SRC_2, d2});
        @(posedge clk);
        #1;
        if (s_a1) begin rem1--; d1++; end
        if (s_a2) begin rem2--; d2++; end
        drive();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        rem1 = 0;
        rem2 = 0;
        drive();
        bus.out_ready = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start(input int r1, input int r2, input logic [WIDTH-1:0] dd1,
                         input logic [WIDTH-1:0] dd2);
        rem1 = r1;
        rem2 = r2;
        d1   = dd1;
        d2   = dd2;
        drive();
    endtask

    task automatic drain(input string tag);
        rem1 = 0;
        rem2 = 0;
        drive();
        for (int i = 0; i < 12 && sbq.size() != 0; i++) cycle();
        chk(tag, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rem1 = 0; rem2 = 0; d1 = '0; d2 = '0;
        drive();
        bus.out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_src",   32'(bus.out_src),   32'd0);
        chk("rst_sel",       32'(bus.sel),       32'd0);
        chk("rst_ready_1",   32'(bus.ready_1),   32'd0);
        chk("rst_ready_2",   32'(bus.ready_2),   32'd0);
        chk("rst_state",     32'(dut.state_q),   32'(IDLE));
        chk("rst_lsp",       32'(dut.lsp_q),     32'd0);
        chk("rst_cnt",       32'(dut.cnt_q),     32'd0);
`ifdef STD_MUX_ARB_STATS_EN
        chk("rst_beats_1", 32'(beats_1), 32'd0);
        chk("rst_beats_2", 32'(beats_2), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Single requester: 4-beat burst, re-grant through IDLE, then 2 beats.
        start(6, 0, 4'd1, 4'd0);
        pat = 9'b111011110;
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("s1_ready_1", 32'(s_r1), 32'(pat[k]));
            chk("s1_ready_2", 32'(s_r2), 32'd0);
            if (k == 1) chk("s1_sel", 32'(s_sel), 32'd1);
        end
        drain("s1_drain");

        // Tie from reset: 4 beats of requester 1, 4 of requester 2, repeat.
        do_reset();
        start(100, 100, 4'd1, 4'd8);
        for (int k = 0; k < 17; k++) begin
            cycle();
            chk("tie_acc_1", 32'(s_a1), 32'((k >= 1) && (((k - 1) / MAX_BURST) % 2 == 0)));
            chk("tie_acc_2", 32'(s_a2), 32'((k >= 1) && (((k - 1) / MAX_BURST) % 2 == 1)));
        end
`ifdef STD_MUX_ARB_STATS_EN
        chk("stats_beats_1", 32'(beats_1), 32'd8);
        chk("stats_beats_2", 32'(beats_2), 32'd8);
`endif
        drain("tie_drain");

        // Early release: requester 2 stops after 2 beats, requester 1 waiting.
        do_reset();
        start(0, 2, 4'd0, 4'd8);
        cycle();
        rem1 = 5;
        d1   = 4'd1;
        drive();
        pat = 9'b000010000;
        for (int k = 1; k < 5; k++) begin
            cycle();
            chk("er_acc_1", 32'(s_a1), 32'(pat[k]));
            chk("er_acc_2", 32'(s_a2), 32'((k == 1) || (k == 2)));
        end
        chk("er_state", 32'(s_st),  32'(BUSY_1));
        chk("er_lsp",   32'(s_lsp), 32'd0);
        chk("er_sel",   32'(s_sel), 32'd1);
        drain("er_drain");

        // Backpressure for 3 cycles after beat 2; burst still ends at 4 beats.
        do_reset();
        start(6, 0, 4'd1, 4'd0);
        pat = 9'b011000110;
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("bp_acc_1", 32'(s_a1), 32'(pat[k]));
            if (k >= 3 && k <= 5) begin
                chk("bp_ready_1",   32'(s_r1),  32'd0);
                chk("bp_out_valid", 32'(s_ov),  32'd1);
                chk("bp_out_data",  32'(s_od),  32'd2);
                chk("bp_cnt",       32'(s_cnt), 32'd2);
            end
            if (k == 2) bus.out_ready = 1'b0;
            if (k == 5) bus.out_ready = 1'b1;
        end
        chk("bp_end_state", 32'(s_st),  32'(IDLE));
        chk("bp_end_lsp",   32'(s_lsp), 32'd1);
        drain("bp_drain");

        // Asynchronous reset after beat 2 of requester 1.
        do_reset();
        start(10, 0, 4'd1, 4'd0);
        for (int k = 0; k < 3; k++) cycle();
        chk("mr_pre_out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_out_data",  32'(bus.out_data),  32'd0);
        chk("mr_state",     32'(dut.state_q),   32'(IDLE));
        chk("mr_ready_1",   32'(bus.ready_1),   32'd0);
        chk("mr_cnt",       32'(dut.cnt_q),     32'd0);
        sbq.delete();
        rem1 = 0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        start(100, 100, 4'd3, 4'd9);
        cycle();
        cycle();
        chk("mr_tie_acc_1", 32'(s_a1),  32'd1);
        chk("mr_tie_acc_2", 32'(s_a2),  32'd0);
        chk("mr_tie_sel",   32'(s_sel), 32'd1);
        drain("mr_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/std_mux_arb.md
# std_mux_arb

Round-robin arbiter and sequencer for the two-input bus mux. It shares one registered output channel between two valid/ready requesters and drives the mux select. Each winner holds the channel for a burst of up to `MAX_BURST` beats. It sits in front of a downstream consumer that sees a single merged stream tagged with its source.

## Interface
Parameters:
- `WIDTH`, default 4: data bus width.
- `MAX_BURST`, default 4: maximum beats per grant; legal range 1..15.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `valid_1`, in, 1: requester 1 has a beat.
- `data_1`, in, `WIDTH`: requester 1 data.
- `ready_1`, out, 1: requester 1 beat accepted this cycle when `valid_1` is also high.
- `valid_2`, in, 1: requester 2 has a beat.
- `data_2`, in, `WIDTH`: requester 2 data.
- `ready_2`, out, 1: requester 2 beat accepted this cycle when `valid_2` is also high.
- `sel`, out, 1: mux select; 1 = requester 1, 0 = requester 2.
- `out_valid`, out, 1: output register holds a beat.
- `out_data`, out, `WIDTH`: output beat.
- `out_src`, out, 1: source of the output beat; 1 = requester 1.
- `out_ready`, in, 1: downstream accepts the output beat.

## Operation
- FSM states are IDLE, BUSY_1 and BUSY_2. There is also a last-served pointer `lsp`, where 1 means requester 1 was served last.
- Reset values:
  - state = IDLE, `lsp` = 0, so requester 1 wins the first tie.
  - burst count = 0.
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0, `sel` = 0, `ready_1` = `ready_2` = 0.
- IDLE transitions:
  - Only `valid_1` high: go to BUSY_1.
  - Only `valid_2` high: go to BUSY_2.
  - Both high: grant the requester not equal to `lsp`.
  - No beat is accepted in IDLE.
- BUSY_x behaviour:
  - `sel` = x.
  - `ready_x` = `~out_valid | out_ready`; the other ready is 0.
  - Accept condition: `valid_x & ready_x`. On accept, `out_data` <= `data_x`, `out_src` <= x, `out_valid` <= 1, and the burst count increments.
- Release from BUSY_x happens on either event:
  - A beat is accepted with count == `MAX_BURST`-1.
  - `valid_x` is low.
- On release:
  - `lsp` <= x and the count clears.
  - If the other requester is valid, the next state is BUSY_other with no idle bubble. Otherwise the next state is IDLE.
- Output register:
  - `out_valid` clears on `out_ready` when no new accept happens in the same cycle.
  - Simultaneous drain and accept replaces the beat, and `out_valid` stays 1.
- Backpressure: while `out_valid & ~out_ready`, no beat is accepted. The burst count and state hold.
- Asynchronous reset mid-burst returns every register to its reset value immediately. A partially sent burst is abandoned.

## Timing
- Grant latency: 1 cycle from `valid_x` rising in IDLE to `ready_x` high.
- Data latency: 1 cycle from accept to `out_valid`/`out_data`.
- Throughput: 1 beat/cycle within a burst and across back-to-back handover between requesters.
- `ready_x` is combinational from state, `out_valid` and `out_ready` only. There is no path from `valid_x` to `ready_x`.
- `sel` is registered (it follows state) and is stable for a whole grant.

## Configuration
- Macro `STD_MUX_ARB_STATS_EN`.
- When defined, the block adds two outputs, `beats_1` and `beats_2`, each 16 bits. They are saturating counts of accepted beats per requester and reset to 0.
- When undefined, those ports and counters are absent. All other behaviour is identical.

## Structure
- Package `std_mux_pkg` holds:
  - the state enum (IDLE, BUSY_1, BUSY_2);
  - the `SRC_1`/`SRC_2` select constants;
  - the stats counter width (16).
- Sub-module `std_mux_arb_rr` holds the round-robin pick between `valid_1`/`valid_2` and `lsp`.
- The top module holds the FSM, burst counter, output register and optional stats.

## Test plan
- Single requester: reset, then `valid_1` = 1 for 6 cycles with data 1..6 and `out_ready` = 1. Expected: `ready_1` from cycle 1. Output beats 1,2,3,4 (burst end). A 1-cycle re-grant via IDLE follows, then beats 5,6. All beats have `out_src` = 1.
- Tie at reset: `valid_1` = `valid_2` = 1 continuously, `out_ready` = 1. Expected: 4 beats from requester 1, then 4 from requester 2 with no bubble, alternating thereafter.
- Early release: requester 2 drops `valid_2` after 2 beats while `valid_1` = 1. Expected: the next cycle is BUSY_1 and `lsp` = 0.
- Backpressure: hold `out_ready` = 0 for 3 cycles mid-burst. Expected: `out_data` is stable, `ready_x` = 0, and the count is held. On release, the burst resumes and completes at 4 total beats.
- Reset mid-burst: assert `rst` after beat 2 of requester 1. Expected: `out_valid` = 0 and state IDLE immediately. After reset, a tie goes to requester 1.
- With `STD_MUX_ARB_STATS_EN` defined, run the tie scenario for 16 cycles. Expected: `beats_1` = 8 and `beats_2` = 8 at the end.
